mdu_unit: RTL and testbench
===========================

# mdu_unit

Parametrised iterative multiply/divide unit implementing the RV32M operation set for the execute stage. It generalises the execute-stage ALU decode to the funct7 = 7'h01 opcode space and runs multi-cycle mul/div behind a start/busy/done handshake. The pipeline stalls on `busy`, and the unit is squashed by `flush`.

## Interface
- `XLEN`, default 32: operand and result width; must be ≥ 4 and even.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE or DONE.
- `funct3`  in  3  operation select, sampled with `start`.
- `op_a`  in  XLEN  rs1 value, sampled with `start`.
- `op_b`  in  XLEN  rs2 value, sampled with `start`.
- `flush`  in  1  abort the in-flight operation.
- `busy`  out  1  operation in progress; pipeline must stall.
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  XLEN  registered result; held until the next accepted start.

## Operation
- funct3 encoding:
  - 0 MUL: low XLEN bits.
  - 1 MULH: signed×signed, high XLEN bits.
  - 2 MULHSU: signed×unsigned, high XLEN bits.
  - 3 MULHU: unsigned×unsigned, high XLEN bits.
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- States:
  - IDLE --start--> MUL | DIV | DONE (fast path).
  - MUL/DIV --counter==XLEN-1--> DONE.
  - DONE --start--> MUL | DIV | DONE.
  - DONE --no start--> IDLE.
- On accept:
  - Latch operand magnitudes: two's-complement absolute value for each operand treated as signed by the op.
  - Latch the result-sign flag.
  - Latch funct3.
  - Clear the iteration counter (width clog2(XLEN)).
- MUL state: radix-2 shift-add, one bit per cycle, into a 2·XLEN product register.
- DIV state: restoring division, one quotient bit per cycle; XLEN+1-bit trial subtract.
- Entering DONE:
  - Apply sign correction. Products are negated when operand signs differ. Quotient is negated when signs differ. Remainder takes the dividend sign.
  - Select the low or high half, or quotient or remainder, into `result`.
- Fast path, bypassing iteration; decided at accept from the sampled operands:
  - op_b == 0, DIV/DIVU: quotient = all ones.
  - op_b == 0, REM/REMU: remainder = op_a.
  - DIV with op_a = most-negative and op_b = all ones: quotient = op_a.
  - REM with the same operands: remainder = 0.
- Restrictions:
  - `start` while in MUL/DIV is ignored.
  - Reserved funct7 checking is the decoder's job, not this block's.
- Reset values: state IDLE; `busy` 0; `done` 0; `result` 0; internal registers 0.

## Timing
- Start accepted at the edge ending cycle T.
- Iterative ops:
  - `busy` = 1 in cycles T+1 .. T+XLEN.
  - DONE in cycle T+XLEN+1, with `done` = 1, `busy` = 0, `result` valid.
  - Total latency XLEN+1 cycles.
- Fast path: DONE in T+1; `busy` never asserts.
- Back-to-back: `start` in the DONE cycle is accepted, and `done` still pulses in that cycle.
- `flush` is synchronous:
  - Any state → IDLE next cycle; `busy` 0, no `done` pulse.
  - `result` is unchanged.
  - `flush` and `start` in the same cycle: flush wins, start is dropped.
- `rst` mid-operation: IDLE next cycle; outputs at reset values; no `done`.
- `done` is never high for two consecutive cycles unless two ops complete back-to-back via the fast path.

## Structure
- Package `mdu_pkg` contains:
  - funct3 op localparams (MUL … REMU).
  - The state enum (IDLE, MUL, DIV, DONE).
  - A `mdu_is_signed_a`/`mdu_is_signed_b` helper function.
- Sub-module `mdu_div_core`: the restoring-division datapath (remainder/quotient shift registers and trial subtractor), instantiated by `mdu_unit`.
- The multiply datapath stays inline.

## Test plan
All scenarios use XLEN = 32 with start at cycle T.
- MUL 7 × 0xFFFFFFFD (−3): `busy` high T+1..T+32, then `done` at T+33 with result 0xFFFFFFEB.
- 0xFFFFFFFF × 0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- Signed division:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU → 2.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF with `done` at T+1 and no `busy`.
  - REM 5/0 → 5.
- Overflow:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM → 0.
  - Both complete at T+1.
- Control:
  - `start` at T+5 during a DIV is ignored; `done` is still at T+33.
  - `flush` at T+10 gives `busy` = 0 at T+11, no `done`, and the previous `result` is kept.
  - `rst` at T+20 gives all outputs 0 next cycle.
  - A new start in the DONE cycle produces the second `done` 33 cycles later.

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg
// Shared definitions for the RV32M multiply/divide unit:
//   - funct3 operation codes (MUL .. REMU)
//   - FSM state encodings (IDLE, MUL, DIV, DONE)
//   - helpers telling which operands an operation treats as signed
// ============================================================================
package mdu_pkg;

    // funct3 operation select within the funct7 = 7'h01 opcode space
    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    // Controller state type and its four encodings
    typedef logic [1:0] mdu_state_t;

    localparam mdu_state_t ST_IDLE = 2'd0;
    localparam mdu_state_t ST_MUL  = 2'd1;
    localparam mdu_state_t ST_DIV  = 2'd2;
    localparam mdu_state_t ST_DONE = 2'd3;

    // rs1 is signed for MULH, MULHSU, DIV and REM
    function automatic logic mdu_is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV)  || (f3 == F3_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM (MULHSU keeps rs2 unsigned)
    function automatic logic mdu_is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// ============================================================================
// mdu_div_core
// Restoring-division datapath: one quotient bit per i_step on unsigned
// magnitudes. The quotient register starts holding the dividend and shifts
// it out MSB-first while quotient bits shift in at the LSB.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_load                capture i_dividend / i_divisor, clear remainder
//   i_step                perform one restoring iteration
//   i_dividend, i_divisor unsigned magnitudes
//   o_quo_next, o_rem_next values the registers take on the next step, so
//                         the controller can capture the final result
//                         on the same edge as the last iteration
// ============================================================================
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quo_next,
    output logic [XLEN-1:0] o_rem_next
);

    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;

    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic            w_fits;

    // Trial subtract is XLEN+1 bits wide: the shifted partial remainder can
    // reach 2*divisor-1, and the borrow bit tells whether the divisor fits.
    // On a miss the shifted value is kept, which is always below the divisor
    // and therefore fits in XLEN bits.
    always_comb begin
        w_shift    = {r_rem, r_quo[XLEN-1]};
        w_trial    = w_shift - {1'b0, r_dvs};
        w_fits     = ~w_trial[XLEN];
        o_rem_next = w_fits ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
        o_quo_next = {r_quo[XLEN-2:0], w_fits};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
        end else if (i_step) begin
            r_rem <= o_rem_next;
            r_quo <= o_quo_next;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// ============================================================================
// mdu_unit
// Iterative RV32M multiply/divide unit for the execute stage. Works on
// operand magnitudes, then applies sign correction when entering DONE.
// Division by zero and signed overflow complete in one cycle.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           request, accepted only in IDLE or DONE
//   i_funct3          operation select, sampled with i_start
//   i_op_a, i_op_b    rs1 / rs2 values, sampled with i_start
//   i_flush           abort in-flight op; wins over i_start
//   o_busy            iterating, pipeline must stall
//   o_done            one-cycle pulse, o_result valid
//   o_result          registered result, held until replaced by a new op
// XLEN must be >= 4 and even.
// ============================================================================
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);

    mdu_state_t        r_state;
    logic [2:0]        r_f3;
    logic              r_neg;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_sign_a;
    logic              w_sign_b;
    logic              w_is_div;
    logic              w_fast;
    logic              w_last;
    logic              w_div_load;
    logic              w_div_step;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN-1:0]   w_min_neg;
    logic [XLEN-1:0]   w_fast_result;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_prod_next;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_mul_fix;
    logic [XLEN-1:0]   w_div_fix;
    logic [XLEN-1:0]   w_quo_next;
    logic [XLEN-1:0]   w_rem_next;

    // Accept decode: operand magnitudes and the one-cycle special cases.
    // Only DIV/REM (funct3[0] == 0) can overflow on most-negative / -1.
    always_comb begin
        w_accept      = i_start && !i_flush &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_sign_a      = mdu_is_signed_a(i_funct3) && i_op_a[XLEN-1];
        w_sign_b      = mdu_is_signed_b(i_funct3) && i_op_b[XLEN-1];
        w_abs_a       = w_sign_a ? -i_op_a : i_op_a;
        w_abs_b       = w_sign_b ? -i_op_b : i_op_b;
        w_is_div      = i_funct3[2];
        w_min_neg     = {1'b1, {(XLEN-1){1'b0}}};
        w_fast        = 1'b0;
        w_fast_result = '0;
        if (w_is_div) begin
            if (i_op_b == '0) begin
                w_fast        = 1'b1;
                w_fast_result = i_funct3[1] ? i_op_a : '1;
            end else if (!i_funct3[0] && (i_op_a == w_min_neg) && (i_op_b == '1)) begin
                w_fast        = 1'b1;
                w_fast_result = i_funct3[1] ? '0 : i_op_a;
            end
        end
    end

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole product right.
    // The final sign fix and half/quotient/remainder selection act on the
    // next-state values so the result lands on the last iteration's edge.
    always_comb begin
        w_sum       = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_prod_next = {w_sum, r_prod[XLEN-1:1]};
        w_prod_fix  = r_neg ? -w_prod_next : w_prod_next;
        w_mul_fix   = (r_f3 == F3_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
        w_div_fix   = r_f3[1] ? w_rem_next : w_quo_next;
        if (r_neg) begin
            w_div_fix = -w_div_fix;
        end
        w_last      = (r_cnt == CW'(XLEN - 1));
        w_div_load  = w_accept && w_is_div && !w_fast;
        w_div_step  = (r_state == ST_DIV) && !i_flush;
    end

    mdu_div_core #(
        .XLEN(XLEN)
    ) u_div_core (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_div_load),
        .i_step     (w_div_step),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_quo_next (w_quo_next),
        .o_rem_next (w_rem_next)
    );

    // Controller. r_neg is the single sign flag for the final fix-up:
    // remainders follow the dividend, everything else follows sign(a)^sign(b).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_f3     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else if (i_flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_MUL: begin
                    r_prod <= w_prod_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result <= w_mul_fix;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result <= w_div_fix;
                        r_state  <= ST_DONE;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_f3    <= i_funct3;
                        r_cnt   <= '0;
                        r_neg   <= (w_is_div && i_funct3[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);
                        r_mcand <= w_abs_a;
                        r_prod  <= {{XLEN{1'b0}}, w_abs_b};
                        if (w_fast) begin
                            r_result <= w_fast_result;
                            r_state  <= ST_DONE;
                        end else if (w_is_div) begin
                            r_state <= ST_DIV;
                        end else begin
                            r_state <= ST_MUL;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_busy   = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign o_done   = (r_state == ST_DONE);
    assign o_result = r_result;

endmodule

// File: tb/tb_mdu_unit.sv
// ============================================================================
// tb_mdu_unit
// Self-checking bench for mdu_unit (XLEN = 32). Expected results come from
// a plain-arithmetic RV32M reference model; expected timing comes from the
// rule "iterative ops finish XLEN+1 cycles after start, divide-by-zero and
// signed overflow finish in one".
// ============================================================================
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int XLEN    = 32;
    localparam int LAT_ITER = XLEN + 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t dirVecs [12] = '{
        '{"mul_7_neg3",    F3_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB},
        '{"mulhu_ones",    F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE},
        '{"mulh_ones",     F3_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000},
        '{"mulhsu_ones",   F3_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF},
        '{"div_neg7_2",    F3_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD},
        '{"rem_neg7_2",    F3_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF},
        '{"divu_100_7",    F3_DIVU,   32'd100,        32'd7,        32'd14},
        '{"remu_100_7",    F3_REMU,   32'd100,        32'd7,        32'd2},
        '{"divu_by_zero",  F3_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF},
        '{"rem_by_zero",   F3_REM,    32'd5,          32'd0,        32'd5},
        '{"div_overflow",  F3_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000},
        '{"rem_overflow",  F3_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000}
    };

    mdu_unit #(
        .XLEN(XLEN)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_funct3 (funct3),
        .i_op_a   (opA),
        .i_op_b   (opB),
        .i_flush  (flush),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics expressed with 64-bit arithmetic
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        q  = '0;
        case (f3)
            F3_MUL:    begin p = ua * ub; return p[31:0];  end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                q = sa / sb;
                return q[31:0];
            end
            F3_DIVU: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                p = ua / ub;
                return p[31:0];
            end
            F3_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                q = sa % sb;
                return q[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    // Divide-by-zero and signed overflow take the one-cycle path
    function automatic bit isFastRef(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 < F3_DIV) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return ((f3 == F3_DIV) || (f3 == F3_REM)) && (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'h7FFFFFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle and follow it to its done pulse.
    // Returns the observed result, cycles from start to done, and busy count.
    task automatic runOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int latency, output int busyCycles);
        funct3 = f3;
        opA    = a;
        opB    = b;
        start  = 1'b1;
        tick();
        start      = 1'b0;
        latency    = 1;
        busyCycles = 0;
        while (done !== 1'b1 && latency < 100) begin
            if (busy === 1'b1) busyCycles++;
            tick();
            latency++;
        end
        res = result;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        opA    = 32'd0;
        opB    = 32'd0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] res;
        int          lat;
        int          bcnt;
        int          expLat;
        int          expBusy;
        foreach (dirVecs[i]) begin
            expLat  = isFastRef(dirVecs[i].f3, dirVecs[i].a, dirVecs[i].b) ? 1 : LAT_ITER;
            expBusy = expLat - 1;
            runOp(dirVecs[i].f3, dirVecs[i].a, dirVecs[i].b, res, lat, bcnt);
            checks++; if (res !== dirVecs[i].exp) begin errors++; $display("[TB] FAIL %s result: got %h expected %h", dirVecs[i].name, res, dirVecs[i].exp); end
            checks++; if (lat != expLat) begin errors++; $display("[TB] FAIL %s latency: got %0d expected %0d", dirVecs[i].name, lat, expLat); end
            checks++; if (bcnt != expBusy) begin errors++; $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", dirVecs[i].name, bcnt, expBusy); end
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL %s done_pulse: got %b expected 0", dirVecs[i].name, done); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] exp;
        int          lat;
        int          bcnt;
        int          expLat;
        for (int i = 0; i < 60; i++) begin
            f3     = 3'($urandom_range(0, 7));
            a      = pickOperand();
            b      = pickOperand();
            exp    = refModel(f3, a, b);
            expLat = isFastRef(f3, a, b) ? 1 : LAT_ITER;
            runOp(f3, a, b, res, lat, bcnt);
            checks++; if (res !== exp) begin errors++; $display("[TB] FAIL rand_result f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, res, exp); end
            checks++; if (lat != expLat) begin errors++; $display("[TB] FAIL rand_latency f3=%0d a=%h b=%h: got %0d expected %0d", f3, a, b, lat, expLat); end
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    task automatic test_ignore_start();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        a      = 32'hFFFFFF9C;
        b      = 32'd7;
        exp    = refModel(F3_DIV, a, b);
        funct3 = F3_DIV;
        opA    = a;
        opB    = b;
        start  = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 5) begin
                funct3 = F3_DIVU;
                opA    = 32'd5;
                opB    = 32'd0;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        checks++; if (lat != LAT_ITER) begin errors++; $display("[TB] FAIL ignore_start_latency: got %0d expected %0d", lat, LAT_ITER); end
        checks++; if (result !== exp) begin errors++; $display("[TB] FAIL ignore_start_result: got %h expected %h", result, exp); end
        tick();
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        int          bcnt;
        int          doneSeen;
        runOp(F3_DIVU, 32'd100, 32'd7, res, lat, bcnt);
        checks++; if (res !== 32'd14) begin errors++; $display("[TB] FAIL flush_setup_result: got %h expected 0000000e", res); end
        tick();
        funct3 = F3_MUL;
        opA    = 32'hFFFF1234;
        opB    = 32'h00005678;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy_before: got %b expected 1", busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy_after: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL flush_done_after: got %b expected 0", done); end
        doneSeen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) doneSeen++;
            tick();
        end
        checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL flush_no_done: got %0d done cycles expected 0", doneSeen); end
        checks++; if (result !== 32'd14) begin errors++; $display("[TB] FAIL flush_result_kept: got %h expected 0000000e", result); end
        funct3 = F3_DIVU;
        opA    = 32'd9;
        opB    = 32'd0;
        start  = 1'b1;
        flush  = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL flush_wins_done: got %b expected 0", done); end
        checks++; if (result !== 32'd14) begin errors++; $display("[TB] FAIL flush_wins_result: got %h expected 0000000e", result); end
        tick();
    endtask

    task automatic test_reset_mid();
        int doneSeen;
        funct3 = F3_DIV;
        opA    = 32'h12345678;
        opB    = 32'd3;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_done: got %b expected 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_result: got %h expected 00000000", result); end
        doneSeen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) doneSeen++;
            tick();
        end
        checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL rst_mid_no_done: got %0d done cycles expected 0", doneSeen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1;
        logic [31:0] b1;
        logic [31:0] a2;
        logic [31:0] b2;
        logic [31:0] res;
        int          lat;
        int          bcnt;
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom & 32'h7FFFFFFF;
        b2 = $urandom | 32'd1;
        runOp(F3_MULHU, a1, b1, res, lat, bcnt);
        checks++; if (res !== refModel(F3_MULHU, a1, b1)) begin errors++; $display("[TB] FAIL b2b_op1_result: got %h expected %h", res, refModel(F3_MULHU, a1, b1)); end
        checks++; if (lat != LAT_ITER) begin errors++; $display("[TB] FAIL b2b_op1_latency: got %0d expected %0d", lat, LAT_ITER); end
        runOp(F3_DIV, a2, b2, res, lat, bcnt);
        checks++; if (res !== refModel(F3_DIV, a2, b2)) begin errors++; $display("[TB] FAIL b2b_op2_result: got %h expected %h", res, refModel(F3_DIV, a2, b2)); end
        checks++; if (lat != LAT_ITER) begin errors++; $display("[TB] FAIL b2b_op2_latency: got %0d expected %0d", lat, LAT_ITER); end
        runOp(F3_DIVU, 32'd11, 32'd0, res, lat, bcnt);
        checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL b2b_fast1_result: got %h expected ffffffff", res); end
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL b2b_fast1_latency: got %0d expected 1", lat); end
        runOp(F3_REM, 32'd7, 32'd0, res, lat, bcnt);
        checks++; if (res !== 32'd7) begin errors++; $display("[TB] FAIL b2b_fast2_result: got %h expected 00000007", res); end
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL b2b_fast2_latency: got %0d expected 1", lat); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_drop: got %b expected 0", done); end
    endtask

    initial begin
        $display("[TB] tb_mdu_unit start");
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
